// File: rtl/ctrl_relogio.sv
// Mode controller and time base for the digital clock: 1 s tick, carry chaining,
// RUN / SET_M / SET_H setting state machine and display blink generation.
module ctrl_relogio #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_btn_mode,
  input  logic       ctrl_btn_inc,
  input  logic       ctrl_add_min,
  input  logic       ctrl_add_hora,
  output logic       ctrl_en_seg,
  output logic       ctrl_en_min,
  output logic       ctrl_en_hora,
  output logic       ctrl_rst_seg,
  output logic [1:0] ctrl_modo,
  output logic       ctrl_blink_min,
  output logic       ctrl_blink_hora
);

  localparam int PW = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_M = 2'd1,
    ST_SET_H = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mode_prev_q, inc_prev_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_q, tick_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic            mode_press, inc_press;

  assign mode_press = ctrl_btn_mode & ~mode_prev_q;
  assign inc_press  = ctrl_btn_inc  & ~inc_prev_q;

  always_ff @(posedge ctrl_clock) begin
    if (!ctrl_reset) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      // Held high so a button kept down through reset does not count as a press.
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      mode_prev_q <= ctrl_btn_mode;
      inc_prev_q  <= ctrl_btn_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_H;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Prescaler only runs while staying in RUN, so re-entry always starts from zero.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      tick_d  = (presc_q == PRESC_MAX);
      presc_d = tick_d ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (state_q != ST_RUN && state_d == state_q) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
      end
    end
  end

  always_comb begin
    ctrl_en_seg     = 1'b0;
    ctrl_en_min     = 1'b0;
    ctrl_en_hora    = 1'b0;
    ctrl_rst_seg    = 1'b1;
    ctrl_blink_min  = 1'b0;
    ctrl_blink_hora = 1'b0;
    ctrl_modo       = state_q;
    case (state_q)
      ST_RUN: begin
        ctrl_en_seg  = tick_q;
        ctrl_en_min  = tick_q & ctrl_add_min;
        ctrl_en_hora = tick_q & ctrl_add_min & ctrl_add_hora;
      end
      ST_SET_M: begin
        ctrl_rst_seg   = 1'b0;
        ctrl_en_min    = inc_press & ~mode_press;
        ctrl_blink_min = phase_q;
      end
      ST_SET_H: begin
        ctrl_rst_seg    = 1'b0;
        ctrl_en_hora    = inc_press & ~mode_press;
        ctrl_blink_hora = phase_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_relogio.sv
// Bench for ctrl_relogio: directed scenarios plus random button/carry traffic,
// checked against a cycle-count reference model.
module tb_ctrl_relogio;

  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, b_mode = 1'b0, b_inc = 1'b0, a_min = 1'b0, a_hora = 1'b0;
  logic en_seg, en_min, en_hora, rst_seg, blink_min, blink_hora;
  logic [1:0] modo;

  ctrl_relogio #(.CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .ctrl_clock(clk), .ctrl_reset(rst_n), .ctrl_btn_mode(b_mode), .ctrl_btn_inc(b_inc),
    .ctrl_add_min(a_min), .ctrl_add_hora(a_hora), .ctrl_en_seg(en_seg), .ctrl_en_min(en_min),
    .ctrl_en_hora(en_hora), .ctrl_rst_seg(rst_seg), .ctrl_modo(modo),
    .ctrl_blink_min(blink_min), .ctrl_blink_hora(blink_hora)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: current mode, cycles elapsed since entering it, previous button levels.
  int m_mode = 0;
  int m_k    = 0;
  bit m_mprev = 1'b1, m_iprev = 1'b1;

  logic [7:0] act, exp_v;
  assign act = {en_seg, en_min, en_hora, rst_seg, modo, blink_min, blink_hora};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_k     <= 0;
      m_mprev <= 1'b1;
      m_iprev <= 1'b1;
    end else begin
      if (b_mode && !m_mprev) begin
        m_mode <= (m_mode + 1) % 3;
        m_k    <= 0;
      end else begin
        m_k <= m_k + 1;
      end
      m_mprev <= b_mode;
      m_iprev <= b_inc;
    end
  end

  function automatic logic [7:0] model_out();
    logic [7:0] v;
    bit tick, mp, ip, ph;
    mp = b_mode && !m_mprev;
    ip = b_inc && !m_iprev;
    ph = ((m_k / BLINK_DIV) % 2) == 1;
    v  = 8'b0001_0000;
    case (m_mode)
      0: begin
        tick = (m_k > 0) && (m_k % CLK_DIV == 0);
        v[7] = tick;
        v[6] = tick && a_min;
        v[5] = tick && a_min && a_hora;
      end
      1: begin
        v[4] = 1'b0; v[3:2] = 2'd1;
        v[6] = ip && !mp;
        v[1] = ph;
      end
      default: begin
        v[4] = 1'b0; v[3:2] = 2'd2;
        v[5] = ip && !mp;
        v[0] = ph;
      end
    endcase
    return v;
  endfunction

  task automatic drive(input bit r, input bit m, input bit i, input bit am, input bit ah);
    @(negedge clk);
    rst_n = r; b_mode = m; b_inc = i; a_min = am; a_hora = ah;
    #1;
    exp_v = model_out();
  endtask

  task automatic press_mode();
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (c > 0) begin
        n_vec++;
        if (act !== 8'b0001_0000) begin
          n_err++;
          $display("FAIL reset cyc %0d: got %b want %b", c, act, 8'b0001_0000);
        end
      end
    end
  endtask

  task automatic test_run_nocarry();
    int pulses = 0;
    for (int c = 0; c <= 13; c++) begin
      drive(1, 0, 0, 0, 0);
      n_vec++;
      if (act !== exp_v || en_seg !== ((c % 4 == 0) && c > 0)) begin
        n_err++;
        $display("FAIL run_nocarry cyc %0d: got %b want %b", c, act, exp_v);
      end
      if (en_seg === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 3) begin
      n_err++;
      $display("FAIL run_nocarry_count: got %0d ticks want 3", pulses);
    end
  endtask

  task automatic test_carry();
    int nseg, nmin, nhora;
    for (int c = 0; c < 40; c++) begin
      drive(1, 0, 0, 1'($urandom), 1'($urandom));
      n_vec++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL carry_rand cyc %0d: got %b want %b", c, act, exp_v);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      nseg = 0; nmin = 0; nhora = 0;
      for (int c = 0; c < 2 * CLK_DIV; c++) begin
        drive(1, 0, 0, 1, 1'(pass));
        nseg += int'(en_seg); nmin += int'(en_min); nhora += int'(en_hora);
      end
      n_vec++;
      if (nseg != 2 || nmin != 2 || nhora != 2 * pass) begin
        n_err++;
        $display("FAIL carry_chain pass %0d: got seg/min/hora %0d/%0d/%0d want 2/2/%0d",
                 pass, nseg, nmin, nhora, 2 * pass);
      end
    end
  endtask

  task automatic test_mode_cycle();
    for (int p = 1; p <= 2; p++) begin
      press_mode();
      for (int c = 0; c < 10; c++) begin
        drive(1, 0, 0, 1'($urandom), 1'($urandom));
        n_vec++;
        if (act !== exp_v || modo !== 2'(p) || rst_seg !== 1'b0 || en_seg !== 1'b0) begin
          n_err++;
          $display("FAIL mode_cycle set%0d cyc %0d: got %b want %b", p, c, act, exp_v);
        end
      end
    end
    drive(1, 1, 0, 0, 0);
    for (int c = 0; c <= 5; c++) begin
      drive(1, 0, 0, 0, 0);
      n_vec++;
      if (act !== exp_v || modo !== 2'd0 || rst_seg !== 1'b1 || en_seg !== (c == 4)) begin
        n_err++;
        $display("FAIL mode_cycle reentry cyc %0d: got %b want %b", c, act, exp_v);
      end
    end
  endtask

  task automatic test_inc();
    int nmin, nhora;
    for (int m = 1; m <= 2; m++) begin
      press_mode();
      nmin = 0; nhora = 0;
      for (int c = 0; c < 10; c++) begin
        drive(1, 0, 1, 1, 1);
        nmin += int'(en_min); nhora += int'(en_hora);
      end
      drive(1, 0, 0, 1, 1);
      for (int r = 0; r < 3; r++) begin
        drive(1, 0, 1, 0, 0);
        nmin += int'(en_min); nhora += int'(en_hora);
        drive(1, 0, 0, 0, 0);
        nmin += int'(en_min); nhora += int'(en_hora);
      end
      n_vec++;
      if ((m == 1 && (nmin != 4 || nhora != 0)) || (m == 2 && (nmin != 0 || nhora != 4))) begin
        n_err++;
        $display("FAIL inc mode %0d: got min/hora pulses %0d/%0d want %0d/%0d",
                 m, nmin, nhora, (m == 1) ? 4 : 0, (m == 2) ? 4 : 0);
      end
    end
    press_mode();
  endtask

  task automatic test_simultaneous();
    int n = 0;
    press_mode();
    drive(1, 1, 1, 0, 0);
    n_vec++;
    if (act !== exp_v || en_min !== 1'b0 || en_hora !== 1'b0) begin
      n_err++;
      $display("FAIL simult press: got %b want %b", act, exp_v);
    end
    drive(1, 0, 0, 0, 0);
    n_vec++;
    if (act !== exp_v || modo !== 2'd2 || en_hora !== 1'b0) begin
      n_err++;
      $display("FAIL simult after: got %b want %b", act, exp_v);
    end
    press_mode();
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, (c % 2 == 0), 0, 0);
      n += int'(en_min) + int'(en_hora);
      n_vec++;
      if (act !== exp_v || modo !== 2'd0) begin
        n_err++;
        $display("FAIL inc_in_run cyc %0d: got %b want %b", c, act, exp_v);
      end
    end
    n_vec++;
    if (n != 0) begin
      n_err++;
      $display("FAIL inc_in_run_count: got %0d pulses want 0", n);
    end
  endtask

  task automatic test_reset_mid();
    press_mode();
    press_mode();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    n_vec++;
    if (act !== 8'b0001_0000) begin
      n_err++;
      $display("FAIL reset_mid: got %b want %b", act, 8'b0001_0000);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, 1, 0, 0, 0);
      n_vec++;
      if (act !== exp_v || modo !== 2'd0) begin
        n_err++;
        $display("FAIL reset_mid held cyc %0d: got %b want %b", c, act, exp_v);
      end
    end
    drive(1, 0, 0, 0, 0);
    press_mode();
    n_vec++;
    if (modo !== 2'd1 || act !== exp_v) begin
      n_err++;
      $display("FAIL reset_mid repress: got %b want %b", act, exp_v);
    end
  endtask

  task automatic test_random();
    bit m = 0, i = 0, r;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) m = ~m;
      if ($urandom_range(3) == 0) i = ~i;
      r = ($urandom_range(99) != 0);
      drive(r, m, i, 1'($urandom), 1'($urandom));
      n_vec++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL random cyc %0d: got %b want %b", c, act, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_nocarry();
    test_carry();
    test_mode_cycle();
    test_inc();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_relogio.md
Name: ctrl_relogio

Overview:
- Mode controller and time base for the digital clock datapath.
- Generates the 1 Hz enable that advances the seconds counter.
- Chains the seconds→minutes→hours carries into counter enables.
- Runs a RUN / SET_M / SET_H state machine so the user can set minutes and hours with two push-buttons; drives blink outputs for the display.

Parameters:
- CLK_DIV, 50_000_000, clock cycles per 1 s tick (≥2).
- BLINK_DIV, 25_000_000, clock cycles per blink phase toggle (≥2).

Ports:
- ctrl_clock  in  1  system clock
- ctrl_reset  in  1  synchronous, active-low reset
- ctrl_btn_mode  in  1  mode button, debounced level, 1 = pressed
- ctrl_btn_inc  in  1  increment button, debounced level, 1 = pressed
- ctrl_add_min  in  1  carry from seconds counter (1 when seconds = 59)
- ctrl_add_hora  in  1  carry from minutes counter (1 when minutes = 59)
- ctrl_en_seg  out  1  one-cycle enable to seconds counter
- ctrl_en_min  out  1  one-cycle enable to minutes counter
- ctrl_en_hora  out  1  one-cycle enable to hours counter
- ctrl_rst_seg  out  1  active-low reset to seconds counter
- ctrl_modo  out  2  current mode: 0 RUN, 1 SET_M, 2 SET_H
- ctrl_blink_min  out  1  1 = blank minutes digits
- ctrl_blink_hora  out  1  1 = blank hours digits

Behaviour:
- Reset: ctrl_reset low at a rising edge causes the following:
  - state = RUN; prescaler = 0; tick = 0; blink counter = 0; blink phase = 0.
  - Button history registers = 1, so a button held through reset is not a press.
  - Outputs after that edge: en_* = 0, rst_seg = 1, modo = 0, blink_* = 0.
  - Reset mid-operation behaves identically and overrides every other event.
- Button edges:
  - Each button is registered once per cycle.
  - press = level & !prev.
  - A press is one cycle long no matter how long the button is held.
- Prescaler (RUN only):
  - Counts 0..CLK_DIV-1 and wraps.
  - Registered tick = 1 for exactly the cycle after the count reaches CLK_DIV-1.
  - In SET_M/SET_H the prescaler and tick are held at 0.
  - On re-entering RUN, the first tick appears CLK_DIV cycles after the entry edge.
- RUN outputs (combinational from registered state and inputs):
  - en_seg = tick.
  - en_min = tick & add_min.
  - en_hora = tick & add_min & add_hora.
  - rst_seg = 1.
- FSM transitions on mode press: RUN→SET_M→SET_H→RUN. No other transitions.
- SET_M:
  - en_min = inc_press; en_seg = en_hora = 0.
  - rst_seg = 0: seconds held at 00 for the whole set period.
- SET_H:
  - en_hora = inc_press; en_seg = en_min = 0; rst_seg = 0.
- Mode and inc pressed in the same cycle: mode wins, inc is ignored (no enable pulse).
- inc press in RUN: ignored.
- Counter wrap (59→00, 23→00) belongs to the counters. The controller never inspects counter values beyond the carries.
- Carries in set modes: add_min/add_hora are ignored. Setting minutes past 59 does not bump hours.
- Blink:
  - Counter counts 0..BLINK_DIV-1 and toggles the phase on wrap.
  - Counter and phase are cleared to 0 on every state change and while in RUN.
  - blink_min = (state==SET_M) & phase.
  - blink_hora = (state==SET_H) & phase.
  - Digits are visible immediately on entering a set mode.
- No output is ever asserted for more than one consecutive cycle, except rst_seg, modo and blink_*.

Test Plan:
- Run, no carries (CLK_DIV=4): release reset, carries = 0 → en_seg pulses at cycles 4, 8, 12 after reset release, each 1 cycle wide; en_min = en_hora = 0; modo = 0.
- Carry chaining: add_min = 1, add_hora = 0 around a tick → en_seg and en_min pulse together, en_hora = 0. Set add_hora = 1 as well → all three pulse in the same cycle.
- Mode cycling (BLINK_DIV=2): 1st mode press → modo = 1, rst_seg = 0, no en_seg ticks, blink_min 0,0,1,1,0… 2nd press → modo = 2, blink_hora toggles. 3rd press → modo = 0, rst_seg = 1, first en_seg exactly 4 cycles later.
- Increment: in SET_M, hold inc for 10 cycles → exactly one en_min pulse. Release and press 3× → 3 en_min pulses. Repeat in SET_H → en_hora pulses only, en_min = 0.
- Simultaneous: mode and inc rise in the same cycle while in SET_M → modo = 2, no en_min or en_hora pulse. inc press in RUN → no pulse.
- Reset mid-operation: assert reset while in SET_H with btn_mode held → after edge modo = 0, rst_seg = 1, blink_* = 0. Keep btn_mode held after release → no transition until the button is released and pressed again.
